// File: rtl/adder_tree_frame_ctrl_pkg.sv
// rtl/adder_tree_frame_ctrl_pkg.sv - shared widths, stage pair type and accumulator states
package adder_tree_frame_ctrl_pkg;

    function automatic int sum_width_f(input int data_width, input int length);
        return data_width + $clog2(length);
    endfunction

    function automatic int acc_width_f(input int data_width, input int length, input int max_frame);
        return sum_width_f(data_width, length) + $clog2(max_frame);
    endfunction

    function automatic int cnt_width_f(input int max_frame);
        return $clog2(max_frame + 1);
    endfunction

    typedef struct packed {
        logic vld;
        logic lst;
    } stage_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/adder_tree_frame_ctrl_if.sv
// rtl/adder_tree_frame_ctrl_if.sv - input, tree and result handshake bundle
interface adder_tree_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int MAX_FRAME  = 256
);
    import adder_tree_frame_ctrl_pkg::*;

    localparam int SUM_WIDTH = sum_width_f(DATA_WIDTH, LENGTH);
    localparam int ACC_WIDTH = acc_width_f(DATA_WIDTH, LENGTH, MAX_FRAME);
    localparam int CNT_WIDTH = cnt_width_f(MAX_FRAME);

    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic                 tree_advance;
    logic [SUM_WIDTH-1:0] tree_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_total;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_overrun;

    modport master (
        output in_valid, in_last, tree_sum, out_ready,
        input  in_ready, tree_advance, out_valid, out_total, out_count, out_overrun
    );

    modport slave (
        input  in_valid, in_last, tree_sum, out_ready,
        output in_ready, tree_advance, out_valid, out_total, out_count, out_overrun
    );

endinterface

// File: rtl/adder_tree_frame_ctrl_tree_shadow_pipe.sv
// rtl/adder_tree_frame_ctrl_tree_shadow_pipe.sv - valid/last shadow of the tree register stages
module tree_shadow_pipe
    import adder_tree_frame_ctrl_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   clear,
    input  logic   advance,
    input  stage_t head,
    output stage_t tail
);

    generate
        if (LATENCY == 0) begin : g_comb
            // Combinational tree: the tail is the input handshake itself.
            logic unused;
            assign unused = &{1'b0, clk, clear, advance};
            assign tail   = head;
        end else begin : g_pipe
            stage_t stg [LATENCY];

            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        stg[i] <= '0;
                    end
                end else if (advance) begin
                    stg[0] <= head;
                    for (int i = 1; i < LATENCY; i++) begin
                        stg[i] <= stg[i-1];
                    end
                end
            end

            assign tail = stg[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/adder_tree_frame_ctrl.sv
// rtl/adder_tree_frame_ctrl.sv - adder tree flow control with per-frame accumulation
module adder_tree_frame_ctrl
    import adder_tree_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int LATENCY    = $clog2(LENGTH),
    parameter int MAX_FRAME  = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    adder_tree_frame_ctrl_if.slave  bus
);

    localparam int SUM_WIDTH = sum_width_f(DATA_WIDTH, LENGTH);
    localparam int ACC_WIDTH = acc_width_f(DATA_WIDTH, LENGTH, MAX_FRAME);
    localparam int CNT_WIDTH = cnt_width_f(MAX_FRAME);

    stage_t               head;
    stage_t               tail;
    acc_state_t           state;
    acc_state_t           state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [ACC_WIDTH-1:0] acc_plus;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] cnt_sat_inc;
    logic                 ovr;
    logic                 ovr_next;
    logic                 at_max;
    logic                 advance;
    logic                 consume;
    logic                 result_load;
    logic                 res_valid;
    logic [ACC_WIDTH-1:0] res_total;
    logic [CNT_WIDTH-1:0] res_count;
    logic                 res_overrun;

    assign head = '{vld: bus.in_valid, lst: bus.in_last};

    tree_shadow_pipe #(
        .LATENCY (LATENCY)
    ) u_shadow (
        .clk     (clk),
        .clear   (reset),
        .advance (advance),
        .head    (head),
        .tail    (tail)
    );

    // Only a last-flagged tail with a result still waiting can block the tree.
    always_comb begin
        advance = !reset && (!tail.vld || !tail.lst || !res_valid || bus.out_ready);
    end

    assign consume     = advance && tail.vld;
    assign at_max      = (cnt == CNT_WIDTH'(MAX_FRAME));
    assign cnt_sat_inc = at_max ? cnt : cnt + CNT_WIDTH'(1);
    assign acc_plus    = acc + ACC_WIDTH'(bus.tree_sum);

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        cnt_next    = cnt;
        ovr_next    = ovr;
        result_load = 1'b0;
        if (consume) begin
            if (tail.lst) begin
                result_load = 1'b1;
                state_next  = IDLE;
                acc_next    = '0;
                cnt_next    = '0;
                ovr_next    = 1'b0;
            end else begin
                state_next  = ACCUM;
                acc_next    = acc_plus;
                cnt_next    = cnt_sat_inc;
                ovr_next    = ovr || at_max;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovr         <= 1'b0;
            res_valid   <= 1'b0;
            res_total   <= '0;
            res_count   <= '0;
            res_overrun <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovr   <= ovr_next;
            // A new result overrides the take so back-to-back frames never bubble.
            if (result_load) begin
                res_valid   <= 1'b1;
                res_total   <= acc_plus;
                res_count   <= cnt_sat_inc;
                res_overrun <= ovr || at_max;
            end else if (res_valid && bus.out_ready) begin
                res_valid   <= 1'b0;
            end
        end
    end

    assign bus.tree_advance = advance;
    assign bus.in_ready     = advance;
    assign bus.out_valid    = res_valid;
    assign bus.out_total    = res_total;
    assign bus.out_count    = res_count;
    assign bus.out_overrun  = res_overrun;

endmodule

// File: tb/tb_adder_tree_frame_ctrl.sv
// tb/tb_adder_tree_frame_ctrl.sv - self-checking bench with tree model and frame scoreboard
module tb_adder_tree_frame_ctrl;

    localparam int DW  = 8;
    localparam int LEN = 4;
    localparam int LAT = 2;
    localparam int MF  = 4;
    localparam int ACC_MOD = 4096;

    typedef struct {
        int total;
        int count;
        int ovr;
    } res_t;

    typedef struct {
        int          nvec;
        logic [31:0] vec;
        int          total;
        int          count;
        int          ovr;
    } vec_rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] vec;
    logic [9:0]  tree_st [LAT];

    int checks = 0;
    int errors = 0;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t mon_got;
    res_t mon_exp;
    int   part_sum = 0;
    int   part_cnt = 0;

    vec_rec_t tbl [8];

    adder_tree_frame_ctrl_if #(.DATA_WIDTH(DW), .LENGTH(LEN), .MAX_FRAME(MF)) bus ();

    adder_tree_frame_ctrl #(
        .DATA_WIDTH (DW),
        .LENGTH     (LEN),
        .LATENCY    (LAT),
        .MAX_FRAME  (MF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int vsum(input logic [31:0] v);
        return int'(v[7:0]) + int'(v[15:8]) + int'(v[23:16]) + int'(v[31:24]);
    endfunction

    // External adder tree: LAT enable-gated register stages.
    always @(posedge clk) begin
        if (bus.tree_advance) begin
            tree_st[0] <= 10'(vsum(vec));
            tree_st[1] <= tree_st[0];
        end
    end
    assign bus.tree_sum = tree_st[LAT-1];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level reference: every accepted vector adds its addends to the open frame.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            part_sum = 0;
            part_cnt = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                mon_got = '{int'(bus.out_total), int'(bus.out_count), int'(bus.out_overrun)};
                obs_q.push_back(mon_got);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_total", mon_got.total, mon_exp.total);
                    check("sb_count", mon_got.count, mon_exp.count);
                    check("sb_overrun", mon_got.ovr, mon_exp.ovr);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                part_sum += vsum(vec);
                part_cnt++;
                if (bus.in_last) begin
                    exp_q.push_back('{part_sum % ACC_MOD, (part_cnt > MF) ? MF : part_cnt,
                                      (part_cnt > MF) ? 1 : 0});
                    part_sum = 0;
                    part_cnt = 0;
                end
            end
        end
    end

    task automatic send_vec(input logic [31:0] v, input logic last, output int stalls);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        vec          = v;
        stalls       = 0;
        @(negedge clk);
        while (!bus.in_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) check("send_timeout", stalls, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        vec = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name, output res_t r);
        int k = 0;
        while (obs_q.size() == 0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (obs_q.size() == 0) begin
            check({name, "_timeout"}, k, 0);
            r = '{-1, -1, -1};
        end else begin
            r = obs_q.pop_front();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        res_t r;
        int   st;
        int   st_sum;
        int   k;

        tbl[0] = '{1, 32'h04030201, 10,   1, 0};
        tbl[1] = '{3, 32'hFFFFFFFF, 3060, 3, 0};
        tbl[2] = '{6, 32'h01010101, 24,   4, 1};
        tbl[3] = '{1, 32'h01010101, 4,    1, 0};
        tbl[4] = '{4, 32'h01010101, 16,   4, 0};
        tbl[5] = '{5, 32'h01010101, 20,   4, 1};
        tbl[6] = '{5, 32'hFFFFFFFF, 1004, 4, 1};
        tbl[7] = '{2, 32'h00000000, 0,    2, 0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        vec           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_tree_advance", int'(bus.tree_advance), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_total", int'(bus.out_total), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        check("rst_out_overrun", int'(bus.out_overrun), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single-vector latency: accept edge, tail two edges later, result after the third.
        obs_q.delete();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        vec          = 32'h04030201;
        @(negedge clk);
        check("lat_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check("lat_cycle3_valid", int'(bus.out_valid), 1);
        check("lat_total", int'(bus.out_total), 10);
        check("lat_count", int'(bus.out_count), 1);
        check("lat_overrun", int'(bus.out_overrun), 0);
        @(posedge clk);
        #1;
        repeat (2) idle_cycle();
        obs_q.delete();

        for (int i = 0; i < 8; i++) begin
            st_sum = 0;
            for (int v = 0; v < tbl[i].nvec; v++) begin
                send_vec(tbl[i].vec, (v == tbl[i].nvec - 1), st);
                st_sum += st;
            end
            wait_result($sformatf("tbl%0d", i), r);
            check($sformatf("tbl%0d_total", i), r.total, tbl[i].total);
            check($sformatf("tbl%0d_count", i), r.count, tbl[i].count);
            check($sformatf("tbl%0d_overrun", i), r.ovr, tbl[i].ovr);
            check($sformatf("tbl%0d_stalls", i), st_sum, 0);
        end

        // Back-pressure: three one-vector frames with the consumer stalled.
        obs_q.delete();
        bus.out_ready = 1'b0;
        send_vec(32'h04030201, 1'b1, st);
        send_vec(32'h08060402, 1'b1, st);
        send_vec(32'h0C090603, 1'b1, st);
        repeat (2) @(negedge clk);
        check("bp_tree_advance", int'(bus.tree_advance), 0);
        check("bp_in_ready", int'(bus.in_ready), 0);
        check("bp_out_valid", int'(bus.out_valid), 1);
        check("bp_held_total", int'(bus.out_total), 10);
        check("bp_nothing_taken", obs_q.size(), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_result("bp_r0", r);
        check("bp_r0_total", r.total, 10);
        wait_result("bp_r1", r);
        check("bp_r1_total", r.total, 20);
        wait_result("bp_r2", r);
        check("bp_r2_total", r.total, 30);
        repeat (10) idle_cycle();
        check("bp_no_duplicate", obs_q.size(), 0);

        // Reset mid-frame discards the partial frame.
        obs_q.delete();
        send_vec(32'h05050505, 1'b0, st);
        send_vec(32'h05050505, 1'b0, st);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        vec          = 32'h07070707;
        @(negedge clk);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_tree_advance", int'(bus.tree_advance), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        send_vec(32'h02020202, 1'b1, st);
        wait_result("mid_rst", r);
        check("mid_rst_total", r.total, 8);
        check("mid_rst_count", r.count, 1);
        check("mid_rst_overrun", r.ovr, 0);

        // Bubbles: in_valid pattern 1,0,0,1,0,1 with garbage addends in the gaps.
        obs_q.delete();
        send_vec(32'h04030201, 1'b0, st);
        idle_cycle();
        idle_cycle();
        send_vec(32'h04030201, 1'b0, st);
        idle_cycle();
        send_vec(32'h04030201, 1'b1, st);
        wait_result("bubble", r);
        check("bubble_total", r.total, 30);
        check("bubble_count", r.count, 3);
        check("bubble_overrun", r.ovr, 0);

        // Randomized traffic with a reset in the middle; the scoreboard checks every result.
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_last   = ($urandom_range(0, 3) == 0);
            vec           = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            reset         = (c == 300);
            @(posedge clk);
            #1;
        end
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rand_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_tree_frame_ctrl.md
# adder_tree_frame_ctrl

- Flow-control and accumulation controller for a pipelined unsigned adder tree.
- Accepts addend vectors over a valid/ready handshake and drives the tree's `advance` enable. Tracks which tree stages hold real data with a shadow valid/last pipeline.
- Sums the tree's per-vector results over a frame delimited by `in_last`, then presents one frame total per frame on a valid/ready output.
- Addend data goes from the source straight to the tree; this block handles control and accumulation only.

## Interface
Parameters:
- `DATA_WIDTH`, 8: addend width.
- `LENGTH`, 4: addends per vector.
- `LATENCY`, `$clog2(LENGTH)`: tree register stages. 0 is legal and means a combinational tree.
- `MAX_FRAME`, 256: nominal maximum vectors per frame.
- Derived values: `SUM_WIDTH = DATA_WIDTH + $clog2(LENGTH)`, `ACC_WIDTH = SUM_WIDTH + $clog2(MAX_FRAME)`, `CNT_WIDTH = $clog2(MAX_FRAME+1)`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  addend vector on the tree inputs is valid
- `in_last`  in  1  final vector of the current frame
- `in_ready`  out  1  vector accepted on this edge when `in_valid` is also high
- `tree_advance`  out  1  tree register enable
- `tree_sum`  in  `SUM_WIDTH`  tree output
- `out_valid`  out  1  frame result valid
- `out_ready`  in  1  consumer accepts the result
- `out_total`  out  `ACC_WIDTH`  frame sum
- `out_count`  out  `CNT_WIDTH`  vectors in the frame, saturating
- `out_overrun`  out  1  frame exceeded `MAX_FRAME` vectors

## Operation
**Shadow pipe.** Stages 1..`LATENCY` each hold a `vld`/`lst` pair. The tail is stage `LATENCY`. When `LATENCY` = 0, the tail is `in_valid`/`in_last` directly.
- On an edge with `tree_advance` = 1:
  - stage 1 loads `in_valid`/`in_last`;
  - stage k loads stage k-1.
- A cycle with `tree_advance` = 1 and `in_valid` = 0 inserts a bubble.
- `tree_advance` = 0 holds every stage.

**Advance rule.**
- `tree_advance = !reset && (!tail_vld || !tail_lst || !out_valid || out_ready)`.
- `in_ready = tree_advance`.
- Every edge with `tree_advance` = 1 and `tail_vld` = 1 consumes `tree_sum` into the accumulator.

**Accumulator.**
- Registers: `acc` (`ACC_WIDTH` bits) and `cnt` (`CNT_WIDTH` bits, saturating at `MAX_FRAME`) hold the open frame. Sticky `ovr` is set when a consume occurs with `cnt` already at `MAX_FRAME`.
- States:
  - IDLE: `acc` = 0, `cnt` = 0.
  - ACCUM: a partial frame is open.
- Transitions, on consume:
  - Non-last vector: `acc += tree_sum` (wraps modulo 2^`ACC_WIDTH`), `cnt++` (saturating), state goes to ACCUM.
  - Last vector: result register loads `out_total = acc + tree_sum`, `out_count = sat(cnt+1)`, and `out_overrun` = `ovr` or this consume overruns. `out_valid` is set. `acc`, `cnt` and `ovr` clear and the state returns to IDLE.
- Result register: `out_valid` clears on `out_valid && out_ready` unless a new result loads on the same edge.
- Simultaneous events: when a result is taken and a new last consume happens on the same edge, the new result loads. No bubble and no loss.
- Accumulation of the next frame continues while a result waits. Only a last-flagged tail stalls, and only while `out_valid && !out_ready`.

**Reset.**
- All `vld` bits, `acc`, `cnt`, `ovr` and `out_valid` clear to 0. `out_total`, `out_count` and `out_overrun` reset to 0.
- `tree_advance` = 0 throughout reset, so no tree stage loads from its inputs during reset.
- Reset mid-frame discards the partial frame and all in-flight vectors.

## Timing
- Vector latency: a last vector accepted at edge 0 reaches the tail during cycle `LATENCY`. `out_valid` rises in cycle `LATENCY+1` when unstalled.
- Throughput: one vector per cycle; no bubbles while `out_ready` = 1.
- `in_ready` depends combinationally on `out_ready` (single-level path). There is no path from `in_valid` to `in_ready`.
- Output-side stall: `tree_advance` drops in the same cycle it is required. The tail value and `tree_sum` hold until released.

## Structure
- Shared package holds:
  - the width functions (`SUM_WIDTH`, `ACC_WIDTH`, `CNT_WIDTH` derivations);
  - a typedef for the `{vld, lst}` stage pair;
  - the IDLE/ACCUM state enum.
- Sub-module `tree_shadow_pipe`: a `LATENCY`-deep enable-gated shift register of stage pairs with a synchronous clear. It handles `LATENCY` = 0 as a pass-through.
- The top level contains the advance logic, accumulator and result register.

## Test plan
Common configuration: `DATA_WIDTH`=8, `LENGTH`=4, `LATENCY`=2, `MAX_FRAME`=4.
- **Single vector:** vector {1,2,3,4} with `in_last`=1 accepted at edge 0, `out_ready`=1, tree model attached → `out_valid` in cycle 3, `out_total`=10, `out_count`=1, `out_overrun`=0.
- **Multi-vector frame:** three vectors {255,255,255,255}, `last` on the third, back-to-back → `out_total`=3060, `out_count`=3, `in_ready` high throughout.
- **Back-pressure:** `out_ready`=0 while three single-vector frames (sums 10, 20, 30) are sent → first result held; `tree_advance` and `in_ready` drop while the second last-vector sits at the tail. After `out_ready`=1, results arrive as 10, 20, 30 with none lost or duplicated.
- **Overrun:** six vectors {1,1,1,1}, `last` on the sixth → `out_total`=24, `out_count`=4, `out_overrun`=1. The next 1-vector frame reports `out_overrun`=0.
- **Reset mid-frame:** two vectors accepted, then 1-cycle reset → `out_valid`=0 and `tree_advance`=0 during reset. A following frame {2,2,2,2} with `last` yields `out_total`=8, `out_count`=1.
- **Bubbles:** `in_valid` toggled 1,0,0,1,0,1 over a 3-vector frame of {1,2,3,4} → `out_total`=30, `out_count`=3; bubbles contribute nothing.
